// File: rtl/zwait_req.sv
// Z80 I/O-cycle front end for the wait generator: decodes gluclock/comport accesses,
// latches the access for the AVR and returns read data. Optional HOLD timeout: ZWAIT_REQ_TIMEOUT_EN.
module zwait_req #(
  parameter logic [15:0] GLU_ADDR  = 16'hBFF7,
  parameter logic [15:0] COM_ADDR  = 16'hBFEF,
  parameter logic [15:0] ADDR_MASK = 16'hFFFF,
  parameter int          TMO_CYC   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] a,
  input  logic [7:0]  d_in,
  input  logic        avr_done,
  input  logic [7:0]  avr_rdata,
  output logic        wait_start_gluclock,
  output logic        wait_start_comport,
  output logic        wait_end,
  output logic [15:0] wait_addr,
  output logic [7:0]  wait_wdata,
  output logic        wait_rnw,
  output logic [7:0]  wait_rdata,
  output logic        wait_tmo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HOLD,
    S_END,
    S_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic        iorq_q, iorq_d;
  logic        start_glu_q, start_glu_d;
  logic        start_com_q, start_com_d;
  logic        end_q, end_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rnw_q, rnw_d;
  logic [7:0]  rdata_q, rdata_d;

  logic glu_hit, com_hit, trigger;

`ifdef ZWAIT_REQ_TIMEOUT_EN
  localparam logic [11:0] TMO_LAST = 12'(TMO_CYC - 1);
  logic [11:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
`endif

  assign glu_hit = (a & ADDR_MASK) == (GLU_ADDR & ADDR_MASK);
  assign com_hit = (a & ADDR_MASK) == (COM_ADDR & ADDR_MASK);
  // Falling edge of IORQ outside INTACK, with a real read or write strobe
  assign trigger = iorq_q & ~iorq_n & m1_n & (~rd_n | ~wr_n) & (glu_hit | com_hit);

  always_comb begin
    state_d     = state_q;
    iorq_d      = iorq_n;
    start_glu_d = 1'b0;
    start_com_d = 1'b0;
    end_d       = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rnw_d       = rnw_q;
    rdata_d     = rdata_q;
`ifdef ZWAIT_REQ_TIMEOUT_EN
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d     = S_START;
          start_glu_d = glu_hit;
          start_com_d = ~glu_hit;
          addr_d      = a;
          wdata_d     = d_in;
          rnw_d       = ~rd_n;
`ifdef ZWAIT_REQ_TIMEOUT_EN
          cnt_d       = '0;
          tmo_d       = 1'b0;
`endif
        end
      end
      S_START: state_d = S_HOLD;
      S_HOLD: begin
        if (avr_done) begin
          state_d = S_END;
          rdata_d = avr_rdata;
          end_d   = 1'b1;
        end
`ifdef ZWAIT_REQ_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          state_d = S_END;
          rdata_d = 8'hFF;
          end_d   = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
`endif
      end
      S_END: state_d = S_RECOVER;
      // Wait for the Z80 to end this I/O cycle so it cannot re-trigger
      S_RECOVER: if (iorq_n) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      iorq_q      <= 1'b1;
      start_glu_q <= 1'b0;
      start_com_q <= 1'b0;
      end_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rnw_q       <= 1'b0;
      rdata_q     <= '0;
`ifdef ZWAIT_REQ_TIMEOUT_EN
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      iorq_q      <= iorq_d;
      start_glu_q <= start_glu_d;
      start_com_q <= start_com_d;
      end_q       <= end_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rnw_q       <= rnw_d;
      rdata_q     <= rdata_d;
`ifdef ZWAIT_REQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign wait_start_gluclock = start_glu_q;
  assign wait_start_comport  = start_com_q;
  assign wait_end            = end_q;
  assign wait_addr           = addr_q;
  assign wait_wdata          = wdata_q;
  assign wait_rnw            = rnw_q;
  assign wait_rdata          = rdata_q;
`ifdef ZWAIT_REQ_TIMEOUT_EN
  assign wait_tmo            = tmo_q;
`else
  assign wait_tmo            = 1'b0;
`endif

endmodule
